nano_mon_uart: RTL and testbench

//  Downstream monitor of the Nano microcontroller system. Drives the 3-bit OUT_CTRL selector and snapshots the
//  OUT8B/OUT4B buses for all 8 selector codes in 16 cycles. Serialises the snapshot as one 8N1 UART frame.

---
 rtl/nano_mon_pkg.sv | 14 +
 rtl/uart_tx_byte.sv | 65 ++++++
 rtl/nano_mon_uart.sv | 120 ++++++++++++
 tb/tb_nano_mon_uart.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/nano_mon_pkg.sv
// nano_mon_pkg: shared FSM encoding and frame constants for the Nano UART monitor
package nano_mon_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPT,
        ST_TX_SYNC,
        ST_TX_DATA,
        ST_TX_CSUM,
        ST_FIN
    } state_t;
    localparam int FRAME_BYTES = 18;
    localparam int SEL_CODES = 8;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serialiser; accepts a new byte in the last stop-bit cycle for gapless chaining
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 163
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       txd_o,
    output logic       ready_o
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    logic          act_q, act_d;
    logic          txd_q, txd_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          last;
    assign last    = baud_q == BW'(CLKS_PER_BIT - 1);
    assign ready_o = !act_q || (last && bit_q == 4'd9);
    assign txd_o   = txd_q;
    // bit timing: start bit on load, data shifted out LSB first, ones shifted in become the stop bit
    always_comb begin
        act_d  = act_q;
        txd_d  = txd_q;
        baud_d = baud_q;
        bit_d  = bit_q;
        sh_d   = sh_q;
        if (load_i && ready_o) begin
            act_d  = 1'b1;
            txd_d  = 1'b0;
            sh_d   = data_i;
            bit_d  = 4'd0;
            baud_d = '0;
        end else if (act_q) begin
            baud_d = last ? '0 : baud_q + 1'b1;
            if (last) begin
                if (bit_q == 4'd9) begin
                    act_d = 1'b0;
                    txd_d = 1'b1;
                end else begin
                    txd_d = sh_q[0];
                    sh_d  = {1'b1, sh_q[7:1]};
                    bit_d = bit_q + 4'd1;
                end
            end
        end
    end
    // serialiser state register, line idles high
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            act_q  <= 1'b0;
            txd_q  <= 1'b1;
            baud_q <= '0;
            bit_q  <= 4'd0;
            sh_q   <= 8'd0;
        end else begin
            act_q  <= act_d;
            txd_q  <= txd_d;
            baud_q <= baud_d;
            bit_q  <= bit_d;
            sh_q   <= sh_d;
        end
    end
endmodule

// File: rtl/nano_mon_uart.sv
// nano_mon_uart: walks OUT_CTRL through all codes, snapshots OUT8B/OUT4B and sends them as one UART frame
module nano_mon_uart
    import nano_mon_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 163,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic       start_i,
    input  logic       auto_en_i,
    input  logic [7:0] d8_i,
    input  logic [3:0] d4_i,
    output logic [2:0] sel_o,
    output logic       txd_o,
    output logic       busy_o,
    output logic       done_o
);
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  csum_q, csum_d;
    logic [11:0] snap_q [SEL_CODES];
    logic [7:0]  tx_byte, data_byte;
    logic        tx_load, tx_ready;
    logic [3:0]  dk;
    logic [2:0]  ds;
    logic [11:0] de;
    assign busy_o    = state_q != ST_IDLE && state_q != ST_FIN;
    assign done_o    = state_q == ST_FIN;
    assign sel_o     = state_q == ST_CAPT ? cnt_q[3:1] : 3'd0;
    assign dk        = idx_q[3:0] - 4'd1;
    assign ds        = dk[3:1];
    assign de        = snap_q[ds];
    assign data_byte = dk[0] ? {1'b0, ds, de[3:0]} : de[11:4];
    // frame sequencing: capture walk, then sync/data/checksum bytes fed whenever the serialiser is ready
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        tx_byte = data_byte;
        tx_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = start_i ? ST_CAPT : ST_IDLE;
                cnt_d   = 4'd0;
            end
            ST_CAPT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = ST_TX_SYNC;
                    idx_d   = 5'd0;
                    csum_d  = 8'd0;
                end
            end
            ST_TX_SYNC: begin
                tx_byte = SYNC_BYTE;
                tx_load = tx_ready;
                if (tx_ready) begin
                    idx_d   = 5'd1;
                    state_d = ST_TX_DATA;
                end
            end
            ST_TX_DATA: begin
                tx_load = tx_ready;
                if (tx_ready) begin
                    csum_d  = csum_q ^ data_byte;
                    idx_d   = idx_q + 5'd1;
                    state_d = idx_q == 5'(FRAME_BYTES - 2) ? ST_TX_CSUM : ST_TX_DATA;
                end
            end
            ST_TX_CSUM: begin
                tx_byte = csum_q;
                tx_load = tx_ready && idx_q == 5'(FRAME_BYTES - 1);
                if (tx_ready) begin
                    idx_d   = 5'(FRAME_BYTES);
                    state_d = idx_q == 5'(FRAME_BYTES) ? ST_FIN : ST_TX_CSUM;
                end
            end
            ST_FIN: begin
                state_d = (start_i || auto_en_i) ? ST_CAPT : ST_IDLE;
                cnt_d   = 4'd0;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    // control registers
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= 5'd0;
            csum_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
        end
    end
    // snapshot latch on the second cycle of each selector code, after the bus has settled
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            for (int i = 0; i < SEL_CODES; i++) snap_q[i] <= 12'd0;
        end else if (state_q == ST_CAPT && cnt_q[0]) begin
            snap_q[cnt_q[3:1]] <= {d8_i, d4_i};
        end
    end
    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk_i  (clk_i),
        .nrst_i (nrst_i),
        .load_i (tx_load),
        .data_i (tx_byte),
        .txd_o  (txd_o),
        .ready_o(tx_ready)
    );
endmodule

// File: tb/tb_nano_mon_uart.sv
// tb_nano_mon_uart: directed checks of capture walk, frame contents, timing, freeze, reset and auto-repeat
module tb_nano_mon_uart;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic start = 1'b0;
    logic auto_en = 1'b0;
    logic ff = 1'b0;
    logic [7:0] d8;
    logic [3:0] d4;
    logic [2:0] sel;
    logic txd, busy, done;
    logic [7:0] rx [18];
    logic [7:0] exp_b [18] = '{8'hA5, 8'h10, 8'h0F, 8'h11, 8'h1E, 8'h12, 8'h2D, 8'h13, 8'h3C,
                               8'h14, 8'h4B, 8'h15, 8'h5A, 8'h16, 8'h69, 8'h17, 8'h78, 8'h00};
    int vectors = 0;
    int errs = 0;

    always #5 clk = ~clk;

    always_comb begin
        d8 = ff ? 8'hFF : 8'h10 + {5'd0, sel};
        d4 = ~{1'b0, sel};
    end

    nano_mon_uart #(.CLKS_PER_BIT(4)) dut (
        .clk_i    (clk),
        .nrst_i   (nrst),
        .start_i  (start),
        .auto_en_i(auto_en),
        .d8_i     (d8),
        .d4_i     (d4),
        .sel_o    (sel),
        .txd_o    (txd),
        .busy_o   (busy),
        .done_o   (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic pulse();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic rx_frame(input int hook, output int bad);
        logic v;
        bad = 0;
        v = 1'b1;
        for (int i = 0; i < 18; i++)
            for (int b = 0; b < 10; b++)
                for (int j = 0; j < 4; j++) begin
                    if (hook == 1 && i == 0 && b == 0 && j == 0) ff = 1'b1;
                    if (hook == 1 && i == 3 && b == 4) start = (j == 0);
                    if (hook == 2 && i == 5 && b == 3 && j == 1) begin
                        nrst = 1'b0;
                        #1;
                        check("rst_txd", txd, 1);
                        check("rst_busy", busy, 0);
                        check("rst_done", done, 0);
                        return;
                    end
                    if (j == 0) v = txd;
                    else if (txd !== v) bad++;
                    if (b == 0 && v !== 1'b0) bad++;
                    if (b == 9 && v !== 1'b1) bad++;
                    if (b >= 1 && b <= 8) rx[i][b-1] = v;
                    if (done !== 1'b0 || busy !== 1'b1) bad++;
                    step();
                end
    endtask

    task automatic frame(input int hook, input string nm);
        int bad, sw, pi;
        logic [2:0] es;
        check({nm, "_busy_rise"}, busy, 1);
        check({nm, "_sel0"}, sel, 0);
        sw = 0;
        pi = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            es = (k < 16) ? 3'(k >> 1) : 3'd0;
            if (sel !== es) sw++;
            if (txd !== 1'b1) pi++;
        end
        check({nm, "_sel_walk"}, sw, 0);
        check({nm, "_pre_idle"}, pi, 0);
        step();
        check({nm, "_latency"}, txd, 0);
        rx_frame(hook, bad);
        if (hook == 2) return;
        for (int i = 0; i < 18; i++) check($sformatf("%s_byte%0d", nm, i), rx[i], exp_b[i]);
        check({nm, "_bits"}, bad, 0);
        check({nm, "_done"}, done, 1);
        check({nm, "_busy_fin"}, busy, 0);
    endtask

    initial begin
        start = 1'b1;
        step();
        step();
        check("rst_txd0", txd, 1);
        check("rst_sel0", sel, 0);
        check("rst_busy0", busy, 0);
        check("rst_done0", done, 0);
        start = 1'b0;
        nrst = 1'b1;
        step();
        step();
        check("post_rst_busy", busy, 0);
        check("post_rst_txd", txd, 1);
        check("post_rst_sel", sel, 0);

        pulse();
        frame(0, "f2");
        step();
        check("f2_idle_busy", busy, 0);
        check("f2_idle_done", done, 0);

        pulse();
        frame(1, "f4");
        repeat (5) step();
        check("f4_no_second_busy", busy, 0);
        check("f4_no_second_txd", txd, 1);
        ff = 1'b0;

        pulse();
        frame(2, "f5");
        step();
        check("f5_held_busy", busy, 0);
        check("f5_held_txd", txd, 1);
        nrst = 1'b1;
        step();
        pulse();
        frame(0, "f5b");
        step();
        check("f5b_idle", busy, 0);

        auto_en = 1'b1;
        pulse();
        frame(0, "f6a");
        step();
        check("f6_rebusy", busy, 1);
        check("f6_done_low", done, 0);
        auto_en = 1'b0;
        frame(0, "f6b");
        step();
        check("f6_no_third_busy", busy, 0);
        check("f6_no_third_done", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
